// File: rtl/imem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package imem_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_DEPTH = 64;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module imem_array
    import imem_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic            nop,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata,
    output logic            perr
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only moves on a fetch, so it holds while no result is presented
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= nop ? XLEN'(NOP_INSTR) : mem[raddr];
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[waddr] <= ^wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr <= 1'b0;
        end else begin
            perr <= re && !nop && (par_mem[raddr] != ^mem[raddr]);
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/prog_imem.sv
// Programmable instruction memory: CLEAR -> LOAD -> RUN sequencer with fetch port.
// Define IMEM_PARITY_EN to add per-word parity checking.
module prog_imem
    import imem_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_req,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data,
    input  logic                     ld_last,
    output logic                     ld_err,
    input  logic                     fetch_en,
    input  logic [31:0]              pc,
    output logic [XLEN-1:0]          instr,
    output logic                     instr_valid,
    output logic                     fault,
    output logic                     par_err,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            ld_hs;
    logic            ld_in_range;
    logic            fetch_go;
    logic            fetch_bad;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    assign ld_hs       = ld_valid && ld_ready;
    // widened by one bit so the range check stays meaningful for any DEPTH
    assign ld_in_range = ({1'b0, ld_addr} < (AW+1)'(DEPTH));
    assign fetch_go    = fetch_en && (state == RUN);
    assign fetch_bad   = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
    assign busy        = (state != RUN);

    always_comb begin
        we    = 1'b0;
        waddr = ld_addr;
        wdata = ld_data;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = cnt;
            wdata = '0;
        end else if (state == LOAD) begin
            we    = ld_hs && ld_in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            cnt         <= '0;
            ld_ready    <= 1'b0;
            ld_err      <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            ld_err      <= ld_hs && !ld_in_range;
            instr_valid <= fetch_go;
            fault       <= fetch_go && fetch_bad;
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        cnt      <= '0;
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_hs && ld_last) begin
                        state    <= RUN;
                        ld_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (prog_req) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    cnt      <= '0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    imem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (fetch_go),
        .nop   (fetch_bad),
        .raddr (pc[AW+1:2]),
        .rdata (instr),
        .perr  (par_err)
    );

endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem: fetch vector table plus reset/reload sequences.
module tb_prog_imem;
    import imem_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic            clk;
    logic            reset;
    logic            prog_req;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_last;
    logic            ld_err;
    logic            fetch_en;
    logic [31:0]     pc;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            fault;
    logic            par_err;
    logic            busy;

    prog_imem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .prog_req    (prog_req),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_err      (ld_err),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault),
        .par_err     (par_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic        fault;
        logic        perr;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fvec_t;

    exp_t        exp_q[$];
    fvec_t       vecs[11];
    int          checks;
    int          errors;
    logic [31:0] last_instr;
    logic [31:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
            if (e.valid) begin
                check("instr", instr, e.instr);
                check("fault", {31'd0, fault}, {31'd0, e.fault});
                check("par_err", {31'd0, par_err}, {31'd0, e.perr});
                last_instr = e.instr;
            end else begin
                check("instr_hold", instr, last_instr);
            end
        end else begin
            check("idle_valid", {31'd0, instr_valid}, 32'd0);
        end
    endtask

    task automatic push_exp(input logic v, input logic [31:0] i, input logic f, input logic p);
        exp_t e;
        e.valid = v;
        e.instr = i;
        e.fault = f;
        e.perr  = p;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] i, input logic f, input logic p);
        fetch_en = 1'b1;
        pc       = a;
        push_exp(1'b1, i, f, p);
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_ld_err", {31'd0, ld_err}, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        exp_q.delete();
        last_instr = '0;
    endtask

    task automatic release_and_clear();
        int n;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        n = 0;
        check("clear_busy", {31'd0, busy}, 32'd1);
        while (!ld_ready && n < 200) begin
            tick();
            n++;
        end
        check("clear_cycles", n, 64);
        check("clear_busy_end", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        model_mem[a] = d;
        check("ld_err", {31'd0, ld_err}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_instr = '0;
        reset    = 1'b1;
        prog_req = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_last  = 1'b0;
        fetch_en = 1'b0;
        pc       = '0;

        vecs[0]  = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        vecs[1]  = '{32'h0000_0006, 32'h0000_0013, 1'b1};
        vecs[2]  = '{32'h0000_0100, 32'h0000_0013, 1'b1};
        vecs[3]  = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[4]  = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        vecs[5]  = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        vecs[6]  = '{32'h0000_000C, 32'h0000_0013, 1'b0};
        vecs[7]  = '{32'h0000_0010, 32'h0000_0000, 1'b0};
        vecs[8]  = '{32'h0000_00FC, 32'h0000_0000, 1'b0};
        vecs[9]  = '{32'h0000_0003, 32'h0000_0013, 1'b1};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};

        #2;
        assert_reset();
        release_and_clear();

        // fetch issued while still loading yields no result
        fetch_en = 1'b1;
        pc       = 32'h0;
        push_exp(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        fetch_en = 1'b0;

        load_word(6'd0, 32'h0050_0093, 1'b0);
        load_word(6'd1, 32'h00A0_0113, 1'b0);
        load_word(6'd2, 32'h0020_81B3, 1'b0);
        load_word(6'd3, 32'h0000_0013, 1'b1);
        check("run_busy", {31'd0, busy}, 32'd0);
        check("run_ld_ready", {31'd0, ld_ready}, 32'd0);

        // back-to-back fetch table
        for (int i = 0; i < 11; i++) begin
            fetch_en = 1'b1;
            pc       = vecs[i].pc;
            push_exp(1'b1, vecs[i].instr, vecs[i].fault, 1'b0);
            tick();
        end
        fetch_en = 1'b0;
        tick();

        // ld_valid is ignored in RUN
        ld_valid = 1'b1;
        ld_addr  = 6'd0;
        ld_data  = 32'hFFFF_FFFF;
        tick();
        ld_valid = 1'b0;
        fetch(32'h0, 32'h0050_0093, 1'b0, 1'b0);

        // reload request with a fetch in the same cycle
        prog_req = 1'b1;
        fetch_en = 1'b1;
        pc       = 32'h4;
        push_exp(1'b1, 32'h00A0_0113, 1'b0, 1'b0);
        tick();
        prog_req = 1'b0;
        check("reload_busy", {31'd0, busy}, 32'd1);
        check("reload_ld_ready", {31'd0, ld_ready}, 32'd1);
        pc = 32'h8;
        push_exp(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        fetch_en = 1'b0;
        load_word(6'd1, 32'hDEAD_BEEF, 1'b1);
        fetch(32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
        u_dut.u_array.mem[2] = u_dut.u_array.mem[2] ^ 32'h0000_0001;
        fetch(32'h8, model_mem[2] ^ 32'h0000_0001, 1'b0, 1'b1);
`else
        fetch(32'h8, model_mem[2], 1'b0, 1'b0);
`endif

        // reset while a fetch result is being presented
        fetch_en = 1'b1;
        pc       = 32'h0;
        push_exp(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        fetch_en = 1'b0;
        assert_reset();
        release_and_clear();

        // reset mid-LOAD, then reload only word 0
        load_word(6'd0, 32'h1111_1111, 1'b0);
        load_word(6'd1, 32'h2222_2222, 1'b0);
        assert_reset();
        release_and_clear();
        load_word(6'd0, 32'hCAFE_F00D, 1'b1);
        fetch(32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        fetch(32'h4, 32'h0000_0000, 1'b0, 1'b0);
        tick();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_imem.md
PROG_IMEM -- requirements
Module: prog_imem

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two, >= 4).
REQ-003 SHALL derive localparam AW = log2(DEPTH), the word-index width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- prog_req  in  1  in RUN, request re-entry to LOAD.
- ld_valid  in  1  load word offered.
- ld_ready  out  1  load word accepted when ld_valid&ld_ready.
- ld_addr  in  AW  load word index.
- ld_data  in  XLEN  load word.
- ld_last  in  1  final load word.
- ld_err  out  1  one-cycle pulse: accepted load had ld_addr >= DEPTH.
- fetch_en  in  1  fetch request.
- pc  in  32  fetch byte address.
- instr  out  XLEN  fetched instruction.
- instr_valid  out  1  instr and fault qualifier.
- fault  out  1  fetch misaligned or out of range.
- par_err  out  1  parity mismatch on fetch.
- busy  out  1  high whenever state != RUN.

Function
REQ-005 SHALL implement FSM states CLEAR, LOAD and RUN.
REQ-006 CLEAR SHALL write zero to word cnt each cycle, with cnt running 0..DEPTH-1, then enter LOAD; this takes exactly DEPTH cycles and holds ld_ready=0.
REQ-007 LOAD SHALL hold ld_ready=1 and write ld_data to mem[ld_addr] on each handshake; a handshake with ld_last=1 SHALL enter RUN on the next cycle.
REQ-008 A LOAD handshake with ld_addr >= DEPTH (only reachable for non-power-of-two use) SHALL suppress the write and pulse ld_err the next cycle.
REQ-009 RUN SHALL hold ld_ready=0 and ignore ld_valid; prog_req=1 SHALL enter LOAD on the next cycle, and any fetch issued in that same cycle SHALL still complete.
REQ-010 Fetch: fetch_en=1 in RUN SHALL give instr_valid=1 exactly one cycle later, with instr=mem[pc[AW+1:2]], fault=0.
REQ-011 If pc[1:0] != 0 or pc>>2 >= DEPTH, the fetch SHALL return instr=32'h00000013 (NOP) with fault=1 and instr_valid=1.
REQ-012 fetch_en outside RUN SHALL give instr_valid=0 next cycle; instr SHALL hold its last value whenever instr_valid=0.
REQ-013 Back-to-back fetches SHALL sustain one result per cycle.
REQ-014 busy SHALL be combinational from state.

Reset
REQ-015 Asserting reset=0 SHALL immediately set state=CLEAR, cnt=0, ld_ready=0, instr=0, instr_valid=0, fault=0, ld_err=0, par_err=0 and busy=1, including mid-CLEAR, mid-LOAD or mid-fetch.
REQ-016 Memory contents SHALL be undefined until CLEAR completes.

Configuration
REQ-017 With macro IMEM_PARITY_EN defined, each word SHALL store an extra even-parity bit over XLEN bits, computed on every write; a fetch mismatch SHALL set par_err=1 alongside instr_valid=1, with instr still the stored data.
REQ-018 With IMEM_PARITY_EN undefined, no parity storage SHALL exist and par_err SHALL be tied to 0.

Structure
REQ-019 Package imem_pkg SHALL hold the state enum (CLEAR/LOAD/RUN), the NOP constant 32'h00000013 and the default XLEN/DEPTH constants.
REQ-020 Sub-module imem_array SHALL hold the storage, write port, registered read port and the optional parity bit; prog_imem SHALL hold the FSM, counter and address checks.

Verification
REQ-021 Reset release, DEPTH=64 -> busy=1 and ld_ready=0 for 64 cycles, then ld_ready=1; a fetch after load of any unwritten word returns 0.
REQ-022 Load words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 with ld_last on word 3 -> busy=0; fetch pc=0x8 -> next cycle instr=0x002081B3, instr_valid=1, fault=0.
REQ-023 Fetch pc=0x6 and pc=0x100 (DEPTH=64) -> instr=0x00000013, fault=1, instr_valid=1 for each; back-to-back fetches pc=0,4,8 -> three consecutive valid results.
REQ-024 Drive reset=0 mid-LOAD after 2 words -> outputs zero at once; after release, a full 64-cycle CLEAR runs and fetch of word 0 after reload reflects only the new data.
REQ-025 In RUN, prog_req=1 with fetch_en=1 at pc=0x4 -> fetch result valid next cycle, busy=1, ld_ready=1; reload word 1=0xDEADBEEF -> fetch pc=0x4 returns 0xDEADBEEF.
REQ-026 IMEM_PARITY_EN defined: force-flip one stored bit of word 2, fetch pc=0x8 -> par_err=1, instr_valid=1; undefined -> par_err stays 0.
